// File: rtl/mult_accumulator.sv
// Block accumulator for unsigned multiplier products. It sums N products into a
// widened register and offers the block sum on a valid/ready port.
module mult_accumulator #(
    parameter int PW    = 4,
    parameter int N     = 8,
    parameter int ACC_W = 7,
    parameter int CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic [CW-1:0]    cnt
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_next;
    logic             r_ovf;
    logic             w_ovf_next;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_next;
    logic [ACC_W:0]   w_sum;

    // One spare bit catches the carry that marks a wrap of the block sum.
    assign w_sum = {1'b0, r_acc} + (ACC_W + 1)'(p);

    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_ovf_next   = r_ovf;
        w_cnt_next   = r_cnt;
        if (clr) begin
            w_state_next = ACCUM;
            w_acc_next   = '0;
            w_ovf_next   = 1'b0;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (in_valid) begin
                        w_acc_next = w_sum[ACC_W-1:0];
                        w_ovf_next = r_ovf | w_sum[ACC_W];
                        if (r_cnt == LAST) begin
                            w_cnt_next   = '0;
                            w_state_next = HOLD;
                        end else begin
                            w_cnt_next = r_cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        w_state_next = ACCUM;
                        w_acc_next   = '0;
                        w_ovf_next   = 1'b0;
                        w_cnt_next   = '0;
                    end
                end
                default: w_state_next = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_ovf   <= w_ovf_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Handshake flags depend on state alone, so no input reaches them combinationally.
    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign acc_out   = r_acc;
    assign ovf       = r_ovf;
    assign cnt       = r_cnt;

endmodule

// File: doc/mult_accumulator.md
# mult_accumulator

Downstream consumer of the 2x2 combinational multiplier. It accepts one 4-bit product per handshake and sums a block of N products into a widened accumulator. It then presents the block sum on a valid/ready output port. Its role is to turn the multiplier's per-operand products into dot-product style results for the next stage.

## Interface

Parameters:
- PW, 4, width of incoming product (2x2 multiplier output P3..P0)
- N, 8, number of products summed per block (N ≥ 2)
- ACC_W, 7, accumulator/result width; default holds N*9 = 72 without wrap
- CW, 3, block counter width; must satisfy 2^CW ≥ N

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- clr  input  1  synchronous block abort: discard partial sum, restart block
- in_valid  input  1  product p is valid this cycle
- in_ready  output  1  block can accept a product this cycle
- p  input  PW  unsigned product {P3,P2,P1,P0} from multiplier
- out_valid  output  1  acc_out holds a completed block sum
- out_ready  input  1  downstream takes acc_out this cycle
- acc_out  output  ACC_W  block sum, unsigned
- ovf  output  1  sum of current/presented block wrapped past 2^ACC_W-1
- cnt  output  CW  products accepted in current block

## Operation

- Two states: ACCUM, HOLD. Reset state ACCUM.
- Reset values: acc_out=0, cnt=0, ovf=0, out_valid=0, in_ready=1.
- ACCUM: in_ready=1, out_valid=0. Accept when in_valid && in_ready: acc_out <= acc_out + zero-extended p (mod 2^ACC_W); cnt <= cnt+1; ovf <= ovf | carry-out.
- On accept with cnt == N-1: cnt <= 0, go to HOLD. acc_out then holds the final sum.
- HOLD: in_ready=0, out_valid=1. acc_out, ovf frozen. in_valid ignored.
- HOLD with out_ready=1: transfer occurs; next cycle acc_out=0, ovf=0, cnt=0, state ACCUM.
- clr=1 in any state: acc_out=0, cnt=0, ovf=0, state ACCUM next cycle. Any product presented the same cycle is dropped. In HOLD, clr discards the unread sum.
- Priority: rst > clr > handshake.
- in_ready is a function of state only. It does not depend on in_valid or out_ready, so there are no combinational paths from inputs to in_ready or out_valid.

## Timing

- Product accepted on the rising edge where in_valid && in_ready. The sum is visible on acc_out the following cycle.
- out_valid rises 1 cycle after the N-th accept. It stays high until the edge where out_ready=1, so it is held for any number of backpressure cycles.
- Minimum block period is N+1 cycles: N accept cycles plus 1 HOLD cycle. in_ready is low in HOLD, so there is one bubble per block.
- Gaps in in_valid during ACCUM: no state change, acc_out/cnt hold.
- p=0 products still count toward N.
- Reset mid-block or in HOLD: all outputs return to reset values on the next edge. The partial or unread sum is lost.

## Test plan

- Reset: hold rst 2 cycles -> acc_out=0, cnt=0, out_valid=0, ovf=0, in_ready=1.
- Eight back-to-back products p=9 (3x3), out_ready=1 -> out_valid=1 for exactly 1 cycle, 1 cycle after the 8th accept, acc_out=72; next cycle acc_out=0, in_ready=1.
- Products 0,1,2,3,4,6,9,2 with in_valid gaps of 0-3 cycles -> acc_out=27 only after the 8th valid; cnt steps 0..7 on accepts only.
- Complete a block, hold out_ready=0 for 5 cycles while in_valid=1 with p=4 -> acc_out stays at the sum, in_ready=0, cnt=0, no products absorbed; out_ready=1 -> ACCUM next cycle.
- Accept 3 products, pulse clr together with in_valid (p=9), then 8 products p=1 -> out acc_out=8, ovf=0. Separately, assert rst in HOLD -> out_valid=0 next cycle.
- ACC_W=6, eight products p=9 -> acc_out=8 (72 mod 64), ovf=1; ovf=0 after transfer.
